// File: rtl/burst_splitter_if.sv
// Avalon-MM style bus bundle used on both sides of the burst splitter.
// Ports (signals): address, burstcount, read, write, writedata, readdata,
//   readdatavalid, waitrequest.
// modport master: the side that issues commands (drives address/read/write).
// modport slave : the side that accepts commands (drives readdata/waitrequest).
interface burst_splitter_if #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned BURST_WIDTH = 7
);
   logic [ADDR_WIDTH-1:0]  address;
   logic [BURST_WIDTH-1:0] burstcount;
   logic                   read;
   logic                   write;
   logic [31:0]            writedata;
   logic [31:0]            readdata;
   logic                   readdatavalid;
   logic                   waitrequest;

   modport master (
      output address, burstcount, read, write, writedata,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, burstcount, read, write, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/burst_splitter.sv
// Burst splitter: converts Avalon burst reads/writes on the slave side into a
// stream of single-word accesses on the master side.
// Ports:
//   clk           - sole clock, rising edge
//   rst           - asynchronous active-high reset
//   avalon_slave  - burst command/beat side (address, burstcount, read, write,
//                   writedata in; readdata, readdatavalid, waitrequest out)
//   avalon_master - single-word side (address, read, write, writedata out;
//                   readdata, waitrequest in; burstcount tied to 1)
module burst_splitter #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned BURST_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   burst_splitter_if.slave       avalon_slave,
   burst_splitter_if.master      avalon_master
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP  = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0]  ALIGN_MASK = ~ADDR_WIDTH'(3);
   localparam logic [BURST_WIDTH-1:0] ONE        = BURST_WIDTH'(1);
   localparam logic [BURST_WIDTH-1:0] ZERO       = BURST_WIDTH'(0);

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_nxt;
   logic [BURST_WIDTH-1:0]  cnt_reg, cnt_nxt;
   logic [31:0]             rdata_reg;
   logic                    rvalid_reg;

   logic [ADDR_WIDTH-1:0]   slave_addr_al;
   logic [ADDR_WIDTH-1:0]   m_addr;
   logic                    m_read;
   logic                    m_write;
   logic                    s_wait;
   logic                    rd_acc;

   // Low address bits from the slave are meaningless for word accesses.
   assign slave_addr_al = avalon_slave.address & ALIGN_MASK;

   // State and burst counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         addr_reg   <= '0;
         cnt_reg    <= '0;
         rvalid_reg <= 1'b0;
         rdata_reg  <= '0;
      end else begin
         state      <= state_nxt;
         addr_reg   <= addr_nxt;
         cnt_reg    <= cnt_nxt;
         rvalid_reg <= rd_acc;
         if (rd_acc) begin
            rdata_reg <= avalon_master.readdata;
         end
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_reg;
      cnt_nxt   = cnt_reg;
      m_addr    = addr_reg;
      m_read    = 1'b0;
      m_write   = 1'b0;
      s_wait    = 1'b0;
      rd_acc    = 1'b0;

      case (state)
         IDLE: begin
            if (avalon_slave.read) begin
               // Read wins over a simultaneous write; a zero-length read is
               // accepted and dropped by staying in IDLE.
               addr_nxt = slave_addr_al;
               cnt_nxt  = avalon_slave.burstcount;
               if (avalon_slave.burstcount != ZERO) begin
                  state_nxt = RD;
               end
            end else if (avalon_slave.write && (avalon_slave.burstcount != ZERO)) begin
               // First write beat goes straight through to the master side.
               m_write = 1'b1;
               m_addr  = slave_addr_al;
               s_wait  = avalon_master.waitrequest;
               if (!avalon_master.waitrequest) begin
                  addr_nxt = slave_addr_al + ADDR_STEP;
                  cnt_nxt  = avalon_slave.burstcount - ONE;
                  if (avalon_slave.burstcount > ONE) begin
                     state_nxt = WR;
                  end
               end
            end
         end

         WR: begin
            m_write = avalon_slave.write;
            s_wait  = !avalon_slave.write | avalon_master.waitrequest;
            if (avalon_slave.write && !avalon_master.waitrequest) begin
               addr_nxt = addr_reg + ADDR_STEP;
               cnt_nxt  = cnt_reg - ONE;
               if (cnt_reg == ONE) begin
                  state_nxt = IDLE;
               end
            end
         end

         RD: begin
            m_read = 1'b1;
            s_wait = 1'b1;
            if (!avalon_master.waitrequest) begin
               rd_acc   = 1'b1;
               addr_nxt = addr_reg + ADDR_STEP;
               cnt_nxt  = cnt_reg - ONE;
               if (cnt_reg == ONE) begin
                  state_nxt = IDLE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // The IDLE write path is combinational, so it must be blocked in reset.
      if (rst) begin
         m_read  = 1'b0;
         m_write = 1'b0;
         rd_acc  = 1'b0;
      end
   end

   assign avalon_master.address    = m_addr;
   assign avalon_master.read       = m_read;
   assign avalon_master.write      = m_write;
   assign avalon_master.writedata  = avalon_slave.writedata;
   assign avalon_master.burstcount = ONE;

   assign avalon_slave.waitrequest   = s_wait;
   assign avalon_slave.readdata      = rdata_reg;
   assign avalon_slave.readdatavalid = rvalid_reg;

endmodule
